audio_nios_cpu_debug_mem_engine: RTL and testbench

Consumes the system-clock debug command strobes and the 38-bit `jdo` word from the CPU debug slave, and executes the requested debug memory accesses on the CPU's on-chip debug memory through a small Avalon-MM master. Results are returned to the debug slave, which shifts them back out over JTAG, on `MonDReg`, `monitor_ready` and `monitor_error`. It sits directly downstream of the debug slave sysclk stage and upstream of the debug ROM/RAM.

---
 rtl/audio_nios_cpu_debug_mem_engine_if.sv | 43 ++++
 rtl/audio_nios_cpu_debug_mem_engine.sv | 172 +++++++++++++++++
 tb/tb_audio_nios_cpu_debug_mem_engine.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_nios_cpu_debug_mem_engine_if.sv
// rtl/audio_nios_cpu_debug_mem_engine_if.sv - Avalon-MM bus between the debug memory engine and debug ROM/RAM
//
// Purpose: bundles the small Avalon-MM master bus used to reach the CPU's
// on-chip debug memory.
// Signals:
//   avm_address       byte address, {word address, 2'b00}
//   avm_read/write    request strobes, held until avm_waitrequest is low
//   avm_writedata     write data
//   avm_waitrequest   slave stall
//   avm_readdata      read data, qualified by avm_readdatavalid
// Modports: master (engine side), slave (memory side).

interface audio_nios_cpu_debug_mem_engine_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/audio_nios_cpu_debug_mem_engine.sv
// rtl/audio_nios_cpu_debug_mem_engine.sv - executes JTAG debug memory commands over an Avalon-MM master
//
// Purpose: takes the sysclk-domain debug command strobes and the 38-bit jdo
// word from the debug slave, performs single-word reads/writes on the debug
// memory, and returns results on MonDReg / monitor_ready / monitor_error.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   jdo[37:0]                  command word, valid while any strobe is high
//   take_action_ocimem_a       load address from jdo[ADDR_W+1:2]; read too if jdo[34]
//   take_no_action_ocimem_a    read at current address
//   take_action_ocimem_b       write jdo[31:0] at current address
//   avm                        Avalon-MM master bus (registered outputs)
//   MonDReg                    last read data
//   monitor_ready              idle and last operation complete
//   monitor_error              sticky error from the last operation

module audio_nios_cpu_debug_mem_engine #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    audio_nios_cpu_debug_mem_engine_if.master avm,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    // Counter value seen during the last allowed cycle of a wait state.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic [31:0]       mon_d_q;
    logic [31:0]       wdata_q;
    logic [15:0]       cnt_q;
    logic              read_q;
    logic              write_q;
    logic              ready_q;
    logic              error_q;

    logic [ADDR_W-1:0] mon_a_d;
    logic [15:0]       cnt_d;
    logic              any_strobe;
    logic              timed_out;

    // Natural wrap of the ADDR_W-bit adder gives the all-ones -> 0 rollover.
    assign mon_a_d    = mon_a_q + ADDR_W'(1);
    assign cnt_d      = cnt_q + 16'd1;
    assign timed_out  = (cnt_q == CNT_LAST);
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[33:32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (take_action_ocimem_a) begin
                        mon_a_q <= jdo[ADDR_W+1:2];
                        // Lower-priority strobes in the same cycle are lost.
                        error_q <= take_action_ocimem_b | take_no_action_ocimem_a;
                        if (jdo[34]) begin
                            read_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= RD_REQ;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        wdata_q <= jdo[31:0];
                        error_q <= take_no_action_ocimem_a;
                        write_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= WR_REQ;
                    end else if (take_no_action_ocimem_a) begin
                        error_q <= 1'b0;
                        read_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= RD_REQ;
                    end
                end

                RD_REQ: begin
                    if (any_strobe) error_q <= 1'b1;
                    if (!avm.avm_waitrequest) begin
                        read_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RD_WAIT;
                    end else if (timed_out) begin
                        read_q  <= 1'b0;
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                RD_WAIT: begin
                    if (any_strobe) error_q <= 1'b1;
                    if (avm.avm_readdatavalid) begin
                        mon_d_q <= avm.avm_readdata;
                        mon_a_q <= mon_a_d;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (timed_out) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                WR_REQ: begin
                    if (any_strobe) error_q <= 1'b1;
                    if (!avm.avm_waitrequest) begin
                        write_q <= 1'b0;
                        mon_a_q <= mon_a_d;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (timed_out) begin
                        write_q <= 1'b0;
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Address is a plain re-wiring of MonAReg, which only changes in IDLE or
    // on completion, so it is stable for the whole request phase.
    assign avm.avm_address   = {mon_a_q, 2'b00};
    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_writedata = wdata_q;

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_audio_nios_cpu_debug_mem_engine.sv
// tb/tb_audio_nios_cpu_debug_mem_engine.sv - self-checking bench for the debug memory engine

module tb_audio_nios_cpu_debug_mem_engine;

    localparam int TO = 12;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [31:0] mon_d;
    logic        mon_rdy, mon_err;

    audio_nios_cpu_debug_mem_engine_if #(.ADDR_W(9)) bus ();

    audio_nios_cpu_debug_mem_engine #(.ADDR_W(9), .TIMEOUT(TO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tna_a),
        .take_action_ocimem_b    (ta_b),
        .avm                     (bus),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_rdy),
        .monitor_error           (mon_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mem [0:511];
    logic [8:0]  model_addr;
    logic [31:0] exp_rd_q [$];
    logic [42:0] exp_wr_q [$];

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [37:0] jdo_a(input logic [8:0] a, input bit rd);
        logic [37:0] j;
        j = '0;
        j[10:2] = a;
        j[34] = rd;
        return j;
    endfunction

    task automatic strobe(input bit a, input bit na, input bit b, input logic [37:0] j);
        ta_a = a; tna_a = na; ta_b = b; jdo = j;
        tick();
        ta_a = 0; tna_a = 0; ta_b = 0; jdo = '0;
    endtask

    // Avalon slave: stalls 'waits' cycles, then returns read data 'lat' cycles after acceptance.
    task automatic serve(input int waits, input int lat, input bit give_rdv, input bit collide,
                         output bit got, output bit was_wr, output logic [10:0] addr_seen,
                         output logic [31:0] wd_seen, output bit stable);
        got = 0; was_wr = 0; addr_seen = '0; wd_seen = '0; stable = 1;
        for (int i = 0; i < 4 && !(bus.avm_read || bus.avm_write); i++) tick();
        if (!(bus.avm_read || bus.avm_write)) return;
        got = 1; was_wr = bus.avm_write; addr_seen = bus.avm_address; wd_seen = bus.avm_writedata;
        for (int i = 0; i <= waits; i++) begin
            bus.avm_waitrequest = (i < waits);
            if (bus.avm_address !== addr_seen || bus.avm_read !== !was_wr || bus.avm_write !== was_wr ||
                (was_wr && bus.avm_writedata !== wd_seen)) stable = 0;
            tick();
        end
        bus.avm_waitrequest = 0;
        if (bus.avm_read || bus.avm_write) stable = 0;
        if (was_wr) mem[addr_seen[10:2]] = wd_seen;
        else if (give_rdv) begin
            for (int i = 0; i < lat; i++) begin
                if (collide && i == 0) begin ta_b = 1; jdo = 38'h0_5555_5555; end
                tick();
                ta_b = 0; jdo = '0;
                if (bus.avm_write || bus.avm_read) stable = 0;
            end
            bus.avm_readdatavalid = 1; bus.avm_readdata = mem[addr_seen[10:2]];
            tick();
            bus.avm_readdatavalid = 0; bus.avm_readdata = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        tests_run++; if (bus.avm_read !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %b exp 0", bus.avm_read); end
        tests_run++; if (bus.avm_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b exp 0", bus.avm_write); end
        tests_run++; if (bus.avm_address !== 11'h000) begin tests_failed++; $display("FAIL reset_addr: got %h exp 000", bus.avm_address); end
        tests_run++; if (bus.avm_writedata !== 32'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h exp 0", bus.avm_writedata); end
        tests_run++; if (mon_d !== 32'h0) begin tests_failed++; $display("FAIL reset_mondreg: got %h exp 0", mon_d); end
        tests_run++; if (mon_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b exp 1", mon_rdy); end
        tests_run++; if (mon_err !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b exp 0", mon_err); end
        reset = 0;
        tick();
        model_addr = '0;
    endtask

    task automatic test_addr_load_read();
        bit got, wr, st; logic [10:0] a; logic [31:0] wd, e;
        mem[5] = 32'hDEADBEEF; mem[6] = 32'hCAFEF00D;
        strobe(1, 0, 0, jdo_a(9'h005, 0)); model_addr = 9'h005;
        tests_run++; if (bus.avm_read !== 1'b0 || mon_rdy !== 1'b1) begin tests_failed++; $display("FAIL load_only: got rd=%b rdy=%b exp rd=0 rdy=1", bus.avm_read, mon_rdy); end
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        tests_run++; if (bus.avm_read !== 1'b1 || mon_rdy !== 1'b0) begin tests_failed++; $display("FAIL read_n1: got rd=%b rdy=%b exp rd=1 rdy=0", bus.avm_read, mon_rdy); end
        serve(0, 0, 1, 0, got, wr, a, wd, st);
        tests_run++; if (a !== 11'h014 || got !== 1'b1) begin tests_failed++; $display("FAIL read_addr: got %h exp 014", a); end
        tests_run++; if (mon_rdy !== 1'b1) begin tests_failed++; $display("FAIL read_ready_n3: got %b exp 1", mon_rdy); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e) begin tests_failed++; $display("FAIL read_data: got %h exp %h", mon_d, e); end
        tests_run++; if (mon_err !== 1'b0) begin tests_failed++; $display("FAIL read_error: got %b exp 0", mon_err); end
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        serve(0, 0, 1, 0, got, wr, a, wd, st);
        tests_run++; if (a !== 11'h018) begin tests_failed++; $display("FAIL read_incr_addr: got %h exp 018", a); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e) begin tests_failed++; $display("FAIL read2_data: got %h exp %h", mon_d, e); end
    endtask

    task automatic test_write_burst();
        bit got, wr, st; logic [10:0] a; logic [31:0] wd, d, e; logic [42:0] ew;
        strobe(1, 0, 0, jdo_a(9'h1FF, 0)); model_addr = 9'h1FF;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 32'h11111111 : 32'h22222222;
            exp_wr_q.push_back({model_addr, 2'b00, d}); model_addr++;
            strobe(0, 0, 1, {6'b0, d});
            serve(0, 0, 0, 0, got, wr, a, wd, st);
            tests_run++; if (got !== 1'b1 || wr !== 1'b1) begin tests_failed++; $display("FAIL wr_seen%0d: got got=%b wr=%b exp 1 1", k, got, wr); end
            tests_run++; if (mon_rdy !== 1'b1) begin tests_failed++; $display("FAIL wr_ready_n2_%0d: got %b exp 1", k, mon_rdy); end
            ew = exp_wr_q.pop_front();
            tests_run++; if ({a, wd} !== ew) begin tests_failed++; $display("FAIL wr_addr_data%0d: got %h/%h exp %h/%h", k, a, wd, ew[42:32], ew[31:0]); end
        end
        mem[1] = 32'h01010101;
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        serve(0, 0, 1, 0, got, wr, a, wd, st);
        tests_run++; if (a !== 11'h004) begin tests_failed++; $display("FAIL wr_wrap_addr: got %h exp 004", a); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e) begin tests_failed++; $display("FAIL wr_wrap_rd: got %h exp %h", mon_d, e); end
    endtask

    task automatic test_stall();
        bit got, wr, st; logic [10:0] a; logic [31:0] wd, e;
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        serve(10, 0, 1, 0, got, wr, a, wd, st);
        tests_run++; if (st !== 1'b1 || got !== 1'b1) begin tests_failed++; $display("FAIL stall_stable: got %b exp 1", st); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e || mon_rdy !== 1'b1 || mon_err !== 1'b0) begin tests_failed++; $display("FAIL stall_result: got %h rdy=%b err=%b exp %h rdy=1 err=0", mon_d, mon_rdy, mon_err, e); end
    endtask

    task automatic test_timeout();
        bit got, wr, st; logic [10:0] a, ea; logic [31:0] wd, e, prev; int cyc;
        prev = mon_d;
        strobe(0, 1, 0, '0);
        serve(0, 0, 0, 0, got, wr, a, wd, st);
        cyc = 0;
        while (!mon_err && cyc < TO + 5) begin tick(); cyc++; end
        tests_run++; if (cyc !== TO) begin tests_failed++; $display("FAIL timeout_cycles: got %0d exp %0d", cyc, TO); end
        tests_run++; if (mon_rdy !== 1'b1) begin tests_failed++; $display("FAIL timeout_ready: got %b exp 1", mon_rdy); end
        tests_run++; if (mon_d !== prev) begin tests_failed++; $display("FAIL timeout_mondreg: got %h exp %h", mon_d, prev); end
        bus.avm_readdatavalid = 1; bus.avm_readdata = 32'hBAD0BAD0;
        tick();
        bus.avm_readdatavalid = 0; bus.avm_readdata = '0;
        tick();
        tests_run++; if (mon_d !== prev || mon_err !== 1'b1) begin tests_failed++; $display("FAIL late_rdv: got %h err=%b exp %h err=1", mon_d, mon_err, prev); end
        ea = {model_addr, 2'b00};
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        tests_run++; if (mon_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_clear: got %b exp 0", mon_err); end
        serve(0, 1, 1, 0, got, wr, a, wd, st);
        tests_run++; if (a !== ea) begin tests_failed++; $display("FAIL timeout_addr_kept: got %h exp %h", a, ea); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e) begin tests_failed++; $display("FAIL post_timeout_rd: got %h exp %h", mon_d, e); end
    endtask

    task automatic test_collision();
        bit got, wr, st; logic [10:0] a; logic [31:0] wd, e;
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        serve(0, 3, 1, 1, got, wr, a, wd, st);
        tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL collide_no_access: got %b exp 1", st); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e || mon_rdy !== 1'b1 || mon_err !== 1'b1) begin tests_failed++; $display("FAIL collide_result: got %h rdy=%b err=%b exp %h rdy=1 err=1", mon_d, mon_rdy, mon_err, e); end
        strobe(1, 0, 1, jdo_a(9'h020, 0)); model_addr = 9'h020;
        tests_run++; if (bus.avm_write !== 1'b0 || mon_rdy !== 1'b1 || mon_err !== 1'b1) begin tests_failed++; $display("FAIL ab_same_cycle: got wr=%b rdy=%b err=%b exp 0 1 1", bus.avm_write, mon_rdy, mon_err); end
        mem[9'h020] = 32'h20202020;
        exp_rd_q.push_back(mem[model_addr]); model_addr++;
        strobe(0, 1, 0, '0);
        serve(0, 0, 1, 0, got, wr, a, wd, st);
        tests_run++; if (a !== 11'h080) begin tests_failed++; $display("FAIL ab_addr_loaded: got %h exp 080", a); end
        e = exp_rd_q.pop_front();
        tests_run++; if (mon_d !== e || mon_err !== 1'b0) begin tests_failed++; $display("FAIL ab_read: got %h err=%b exp %h err=0", mon_d, mon_err, e); end
    endtask

    task automatic test_back_to_back();
        bit got, wr, st; logic [10:0] a; logic [31:0] wd, e; logic [8:0] ad;
        for (int k = 0; k < 2; k++) begin
            ad = (k == 0) ? 9'h033 : 9'h100;
            mem[ad] = $urandom;
            exp_rd_q.push_back(mem[ad]); model_addr = ad + 9'd1;
            strobe(1, 0, 0, jdo_a(ad, 1));
            tests_run++; if (bus.avm_read !== 1'b1 || bus.avm_address !== {ad, 2'b00}) begin tests_failed++; $display("FAIL ld_rd_req%0d: got rd=%b addr=%h exp 1 %h", k, bus.avm_read, bus.avm_address, {ad, 2'b00}); end
            serve(0, 0, 1, 0, got, wr, a, wd, st);
            e = exp_rd_q.pop_front();
            tests_run++; if (mon_d !== e || mon_rdy !== 1'b1) begin tests_failed++; $display("FAIL ld_rd_data%0d: got %h rdy=%b exp %h rdy=1", k, mon_d, mon_rdy, e); end
        end
    endtask

    task automatic test_reset_in_write();
        bit got, wr, st; logic [10:0] a; logic [31:0] wd;
        strobe(0, 0, 1, 38'h0_ABCD_1234);
        tests_run++; if (bus.avm_write !== 1'b1) begin tests_failed++; $display("FAIL rst_wr_start: got %b exp 1", bus.avm_write); end
        bus.avm_waitrequest = 1;
        tick(); tick();
        reset = 1;
        tick();
        tests_run++; if (bus.avm_write !== 1'b0 || mon_rdy !== 1'b1 || mon_d !== 32'h0) begin tests_failed++; $display("FAIL rst_in_write: got wr=%b rdy=%b d=%h exp 0 1 0", bus.avm_write, mon_rdy, mon_d); end
        reset = 0; bus.avm_waitrequest = 0;
        tick();
        model_addr = '0;
        strobe(0, 1, 0, '0);
        serve(0, 0, 1, 0, got, wr, a, wd, st);
        tests_run++; if (a !== 11'h000 || got !== 1'b1) begin tests_failed++; $display("FAIL rst_addr_zero: got %h exp 000", a); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0; reset = 1;
        bus.avm_waitrequest = 0; bus.avm_readdata = '0; bus.avm_readdatavalid = 0;
        test_reset();
        test_addr_load_read();
        test_write_burst();
        test_stall();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_reset_in_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
